// File: rtl/hazard_ctrl_ng.sv
// Pipeline hazard controller: stall/flush sequencing for F/D/E/MW,
// operand forward selects for E, and stall/flush cycle counters.
module hazard_ctrl_ng #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                           clk,
    input  logic                           CpuRst_n,
    input  logic                           ICacheMiss,
    input  logic                           DCacheMiss,
    input  logic                           BranchE,
    input  logic                           JalrE,
    input  logic                           JalD,
    input  logic [REG_AW-1:0]              Rs1D,
    input  logic [REG_AW-1:0]              Rs2D,
    input  logic [REG_AW-1:0]              Rs1E,
    input  logic [REG_AW-1:0]              Rs2E,
    input  logic [REG_AW-1:0]              RdE,
    input  logic [1:0]                     RegReadE,
    input  logic                           MemToRegE,
    input  logic [FWD_STAGES*REG_AW-1:0]   RdFwd,
    input  logic [FWD_STAGES-1:0]          RegWriteFwd,
    input  logic                           CntClr,
    output logic                           StallF,
    output logic                           FlushF,
    output logic                           StallD,
    output logic                           FlushD,
    output logic                           StallE,
    output logic                           FlushE,
    output logic                           StallMW,
    output logic                           FlushMW,
    output logic [2:0]                     Forward1E,
    output logic [2:0]                     Forward2E,
    output logic [CNT_W-1:0]               StallCnt,
    output logic [CNT_W-1:0]               FlushCnt
);

    localparam int LUW = $clog2(LOAD_LAT + 1);

    typedef enum logic [1:0] {RUN, LU, DMISS, IMISS} state_e;

    state_e           state_q, state_d;
    logic [LUW-1:0]   lu_q, lu_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic redirect_e, ctl_any, lu_hit, in_lu;
    logic sf, sd, se, sm, fd, fe;
    logic stall_any, flush_any;
    logic [2:0] fwd1, fwd2;

    always_comb begin
        redirect_e = BranchE | JalrE;
        ctl_any    = redirect_e | JalD;
        lu_hit     = MemToRegE && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D)) && !redirect_e;
        // Leaving a miss with bubbles still owed behaves as LU in the exit cycle
        in_lu      = (state_q == LU) ||
                     (((state_q == DMISS) || (state_q == IMISS)) && (lu_q != '0));
    end

    always_comb begin
        state_d = state_q;
        lu_d    = lu_q;
        sf = 1'b0;
        sd = 1'b0;
        se = 1'b0;
        sm = 1'b0;
        fd = 1'b0;
        fe = 1'b0;
        if (DCacheMiss) begin
            state_d = DMISS;
            {sf, sd, se, sm} = 4'b1111;
        end else if (ICacheMiss) begin
            state_d = IMISS;
            if (ctl_any) begin
                {sf, sd, se, sm} = 4'b1111;
            end else begin
                sf = 1'b1;
                fd = 1'b1;
            end
        end else if (in_lu) begin
            sf      = 1'b1;
            sd      = 1'b1;
            fe      = 1'b1;
            lu_d    = lu_q - LUW'(1);
            state_d = (lu_d == '0) ? RUN : LU;
        end else begin
            state_d = RUN;
            if (redirect_e) begin
                fd = 1'b1;
                fe = 1'b1;
            end else if (lu_hit) begin
                sf      = 1'b1;
                sd      = 1'b1;
                fe      = 1'b1;
                lu_d    = LUW'(LOAD_LAT - 1);
                state_d = (LOAD_LAT > 1) ? LU : RUN;
            end else if (JalD) begin
                fd = 1'b1;
            end
        end
    end

    // Scan farthest to nearest so the nearest matching stage wins
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (RegReadE[1] && (Rs1E != '0) && RegWriteFwd[k-1] &&
                (RdFwd[(k-1)*REG_AW +: REG_AW] == Rs1E))
                fwd1 = 3'(k);
            if (RegReadE[0] && (Rs2E != '0) && RegWriteFwd[k-1] &&
                (RdFwd[(k-1)*REG_AW +: REG_AW] == Rs2E))
                fwd2 = 3'(k);
        end
    end

    assign StallF    = CpuRst_n & sf;
    assign StallD    = CpuRst_n & sd;
    assign StallE    = CpuRst_n & se;
    assign StallMW   = CpuRst_n & sm;
    assign FlushF    = ~CpuRst_n;
    assign FlushD    = ~CpuRst_n | fd;
    assign FlushE    = ~CpuRst_n | fe;
    assign FlushMW   = ~CpuRst_n;
    assign Forward1E = CpuRst_n ? fwd1 : 3'd0;
    assign Forward2E = CpuRst_n ? fwd2 : 3'd0;

    assign stall_any = StallF | StallD | StallE | StallMW;
    assign flush_any = CpuRst_n & (fd | fe);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_any && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_any && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge CpuRst_n) begin
        if (!CpuRst_n) begin
            state_q     <= RUN;
            lu_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lu_q        <= lu_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_ng.sv
// Bench for hazard_ctrl_ng: directed scenarios plus random traffic
// against a bubble-debt reference model.
module tb_hazard_ctrl_ng;

    localparam int AW = 5;
    localparam int FS = 2;
    localparam int LL = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic CpuRst_n, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic [1:0] RegReadE;
    logic MemToRegE, CntClr;
    logic [FS*AW-1:0] RdFwd;
    logic [FS-1:0] RegWriteFwd;
    logic StallF, FlushF, StallD, FlushD, StallE, FlushE, StallMW, FlushMW;
    logic [2:0] Forward1E, Forward2E;
    logic [CW-1:0] StallCnt, FlushCnt;

    hazard_ctrl_ng #(
        .REG_AW(AW), .FWD_STAGES(FS), .LOAD_LAT(LL), .CNT_W(CW)
    ) dut (
        .clk(clk), .CpuRst_n(CpuRst_n),
        .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegReadE(RegReadE), .MemToRegE(MemToRegE),
        .RdFwd(RdFwd), .RegWriteFwd(RegWriteFwd), .CntClr(CntClr),
        .StallF(StallF), .FlushF(FlushF), .StallD(StallD), .FlushD(FlushD),
        .StallE(StallE), .FlushE(FlushE), .StallMW(StallMW), .FlushMW(FlushMW),
        .Forward1E(Forward1E), .Forward2E(Forward2E),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    int checks = 0;
    int errors = 0;

    // bubbles still owed to an earlier load, and expected counter values
    int m_pend = 0;
    int m_sc = 0;
    int m_fc = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fwd_ref(logic [AW-1:0] rs, logic used);
        for (int k = 1; k <= FS; k++)
            if (used && rs != 0 && RegWriteFwd[k-1] && RdFwd[(k-1)*AW +: AW] == rs)
                return k;
        return 0;
    endfunction

    task automatic idle();
        ICacheMiss = 0; DCacheMiss = 0; BranchE = 0; JalrE = 0; JalD = 0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
        RegReadE = 0; MemToRegE = 0; RdFwd = 0; RegWriteFwd = 0; CntClr = 0;
    endtask

    // Called at a falling edge with inputs set; checks, then advances one cycle
    task automatic step();
        bit sf, sd, se, sm, ff, fd, fe, fm, br, lu;
        int f1, f2;
        {sf, sd, se, sm, ff, fd, fe, fm} = '0;
        f1 = 0;
        f2 = 0;
        br = BranchE | JalrE;
        lu = MemToRegE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && !br;
        if (!CpuRst_n) begin
            m_pend = 0; m_sc = 0; m_fc = 0;
            {ff, fd, fe, fm} = 4'b1111;
        end else begin
            f1 = fwd_ref(Rs1E, RegReadE[1]);
            f2 = fwd_ref(Rs2E, RegReadE[0]);
            if (DCacheMiss) begin
                {sf, sd, se, sm} = 4'b1111;
            end else if (ICacheMiss) begin
                if (br || JalD) {sf, sd, se, sm} = 4'b1111;
                else begin sf = 1; fd = 1; end
            end else if (m_pend > 0) begin
                sf = 1; sd = 1; fe = 1;
                m_pend--;
            end else if (br) begin
                fd = 1; fe = 1;
            end else if (lu) begin
                sf = 1; sd = 1; fe = 1;
                m_pend = LL - 1;
            end else if (JalD) begin
                fd = 1;
            end
        end
        #1;
        chk("StallF", StallF, sf);
        chk("StallD", StallD, sd);
        chk("StallE", StallE, se);
        chk("StallMW", StallMW, sm);
        chk("FlushF", FlushF, ff);
        chk("FlushD", FlushD, fd);
        chk("FlushE", FlushE, fe);
        chk("FlushMW", FlushMW, fm);
        chk("Forward1E", Forward1E, f1);
        chk("Forward2E", Forward2E, f2);
        chk("StallCnt", StallCnt, m_sc);
        chk("FlushCnt", FlushCnt, m_fc);
        if (CpuRst_n) begin
            if (CntClr) begin
                m_sc = 0;
                m_fc = 0;
            end else begin
                if (sf | sd | se | sm) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
                if (fd | fe) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        CpuRst_n = 0;
        @(negedge clk);
        step();
        step();
        CpuRst_n = 1;
        step();

        // forwarding: nearest stage, then farther, then x0
        Rs1E = 5; RegReadE = 2'b10;
        RdFwd = {5'd5, 5'd5}; RegWriteFwd = 2'b11;
        step();
        chk("fwd_near", Forward1E, 1);
        RegWriteFwd = 2'b10;
        step();
        chk("fwd_far", Forward1E, 2);
        Rs1E = 0;
        step();
        chk("fwd_x0", Forward1E, 0);

        // load-use with two bubbles
        idle(); CntClr = 1; step();
        idle(); MemToRegE = 1; RdE = 7; Rs2D = 7; step();
        idle(); step();
        step();
        chk("lu_stallcnt", StallCnt, 2);

        // data miss during LU with one bubble owed
        MemToRegE = 1; RdE = 7; Rs2D = 7; step();
        idle(); DCacheMiss = 1;
        repeat (3) step();
        DCacheMiss = 0; step();
        step();

        // branch held across an instruction miss
        idle(); CntClr = 1; step();
        idle(); BranchE = 1; ICacheMiss = 1;
        repeat (4) step();
        ICacheMiss = 0; step();
        idle(); step();
        chk("br_flushcnt", FlushCnt, 1);

        // counter saturation and clear
        CntClr = 1; step();
        idle(); DCacheMiss = 1;
        repeat (20) step();
        DCacheMiss = 0; step();
        chk("sat_stallcnt", StallCnt, CMAX);
        CntClr = 1; step();
        CntClr = 0;
        chk("clr_stallcnt", StallCnt, 0);

        // reset asserted mid-LU abandons the owed bubble
        MemToRegE = 1; RdE = 3; Rs1D = 3; step();
        idle(); CpuRst_n = 0; step();
        CpuRst_n = 1; step();

        for (int i = 0; i < 3000; i++) begin
            CpuRst_n    = ($urandom_range(0, 99) != 0);
            DCacheMiss  = DCacheMiss ? ($urandom_range(0, 9) < 7)
                                     : ($urandom_range(0, 99) < 4);
            ICacheMiss  = ICacheMiss ? ($urandom_range(0, 9) < 7)
                                     : ($urandom_range(0, 99) < 5);
            BranchE     = ($urandom_range(0, 9) == 0);
            JalrE       = ($urandom_range(0, 19) == 0);
            JalD        = ($urandom_range(0, 9) == 0);
            Rs1D        = AW'($urandom_range(0, 3));
            Rs2D        = AW'($urandom_range(0, 3));
            Rs1E        = AW'($urandom_range(0, 3));
            Rs2E        = AW'($urandom_range(0, 3));
            RdE         = AW'($urandom_range(0, 3));
            RegReadE    = 2'($urandom_range(0, 3));
            MemToRegE   = ($urandom_range(0, 2) == 0);
            RdFwd       = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
            RegWriteFwd = FS'($urandom_range(0, 3));
            CntClr      = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
